pipeline_debug_ctrl: RTL and testbench

PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

---
 rtl/pipeline_debug_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_ctrl.sv
// Debug controller for a pipelined core: gates the pipeline clock-enable for
// run / single-step / halt, counts enabled cycles, and streams a state dump
// (PC, cycle count, register file, data memory) over a valid/ready port.
module pipeline_debug_ctrl #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_MEM  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd,
    output logic                     cmd_ready,
    input  logic                     halt_wb,
    input  logic [9:0]               PC_IFID,
    input  logic [32*NUM_REGS-1:0]   Registers,
    input  logic [32*NUM_MEM-1:0]    Memorias,
    output logic                     pipe_en,
    output logic [31:0]              dump_data,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic                     dump_last,
    output logic [31:0]              cycle_count,
    output logic [1:0]               state
);

    localparam int unsigned NumWords = NUM_REGS + NUM_MEM + 2;
    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

    localparam logic [1:0] CmdRun  = 2'b00;
    localparam logic [1:0] CmdStep = 2'b01;
    localparam logic [1:0] CmdHalt = 2'b10;
    localparam logic [1:0] CmdDump = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StStep = 2'b10,
        StDump = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic            pipe_en_q, pipe_en_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            dump_valid_q, dump_valid_d;
    logic            dump_last_q, dump_last_d;
    logic [31:0]     dump_data_q, dump_data_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            accept;
    logic [31:0]     words [NumWords];

    // Flatten every dumpable source into one word array in stream order.
    always_comb begin
        words[0] = {22'b0, PC_IFID};
        words[1] = cycle_count_q;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            words[i + 2] = Registers[32*i +: 32];
        end
        for (int j = 0; j < int'(NUM_MEM); j++) begin
            words[NUM_REGS + 2 + j] = Memorias[32*j +: 32];
        end
    end

    // Next-state and next-output logic; outputs are derived from the next state.
    always_comb begin
        state_d       = state_q;
        dump_valid_d  = 1'b0;
        dump_last_d   = 1'b0;
        dump_data_d   = dump_data_q;
        idx_d         = idx_q;
        cycle_count_d = pipe_en_q ? cycle_count_q + 32'd1 : cycle_count_q;
        accept        = cmd_valid && cmd_ready_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (cmd)
                        CmdRun:  state_d = StRun;
                        CmdStep: state_d = StStep;
                        CmdDump: begin
                            state_d      = StDump;
                            idx_d        = '0;
                            dump_data_d  = words[0];
                            dump_valid_d = 1'b1;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StRun: begin
                // Pipeline-side halt and host HALT collapse into one transition.
                if (halt_wb || (accept && cmd == CmdHalt)) begin
                    state_d = StIdle;
                end
            end
            StStep: state_d = StIdle;
            StDump: begin
                dump_valid_d = 1'b1;
                dump_last_d  = dump_last_q;
                if (dump_valid_q && dump_ready) begin
                    if (dump_last_q) begin
                        state_d      = StIdle;
                        dump_valid_d = 1'b0;
                        dump_last_d  = 1'b0;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        dump_data_d = words[idx_d];
                        dump_last_d = (idx_d == LastIdx);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        pipe_en_d   = (state_d == StRun) || (state_d == StStep);
        cmd_ready_d = (state_d == StIdle) || (state_d == StRun);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            pipe_en_q     <= 1'b0;
            cmd_ready_q   <= 1'b1;
            dump_valid_q  <= 1'b0;
            dump_last_q   <= 1'b0;
            dump_data_q   <= '0;
            cycle_count_q <= '0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            pipe_en_q     <= pipe_en_d;
            cmd_ready_q   <= cmd_ready_d;
            dump_valid_q  <= dump_valid_d;
            dump_last_q   <= dump_last_d;
            dump_data_q   <= dump_data_d;
            cycle_count_q <= cycle_count_d;
            idx_q         <= idx_d;
        end
    end

    assign state       = state_q;
    assign pipe_en     = pipe_en_q;
    assign cmd_ready   = cmd_ready_q;
    assign dump_valid  = dump_valid_q;
    assign dump_last   = dump_last_q;
    assign dump_data   = dump_data_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Bench for pipeline_debug_ctrl: directed scenarios plus randomized command
// traffic checked against a mode-level reference model.
module tb_pipeline_debug_ctrl;

    localparam int NR = 32;
    localparam int NM = 10;
    localparam int NW = NR + NM + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [1:0]       cmd;
    logic             cmd_ready;
    logic             halt_wb;
    logic [9:0]       pc_v;
    logic [32*NR-1:0] regs_v;
    logic [32*NM-1:0] mem_v;
    logic             pipe_en;
    logic [31:0]      dump_data;
    logic             dump_valid;
    logic             dump_ready;
    logic             dump_last;
    logic [31:0]      cycle_count;
    logic [1:0]       state;

    int checks   = 0;
    int failures = 0;
    int exp_cc   = 0;

    pipeline_debug_ctrl #(.NUM_REGS(NR), .NUM_MEM(NM)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .halt_wb     (halt_wb),
        .PC_IFID     (pc_v),
        .Registers   (regs_v),
        .Memorias    (mem_v),
        .pipe_en     (pipe_en),
        .dump_data   (dump_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_last   (dump_last),
        .cycle_count (cycle_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int k);
        if (k == 0) return {22'b0, pc_v};
        if (k == 1) return exp_cc;
        if (k < NR + 2) return regs_v[32*(k-2) +: 32];
        return mem_v[32*(k-NR-2) +: 32];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_cc = 0;
        checks++;
        if ({state, pipe_en, cmd_ready, dump_valid, dump_last} !== 6'b000100) begin
            failures++;
            $display("FAIL reset_ctrl got st=%0d pe=%0b rdy=%0b dv=%0b dl=%0b want 0 0 1 0 0",
                     state, pipe_en, cmd_ready, dump_valid, dump_last);
        end
        checks++;
        if (cycle_count !== 32'd0 || dump_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got cc=%0d dd=%h want 0 0", cycle_count, dump_data);
        end
    endtask

    task automatic test_step();
        for (int s = 0; s < 3; s++) begin
            repeat ($urandom_range(0, 3)) tick();
            cmd_valid = 1'b1;
            cmd = 2'b01;
            tick();
            cmd_valid = 1'b0;
            checks++;
            if (pipe_en !== 1'b1 || state !== 2'b10 || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL step_on got pe=%0b st=%0d rdy=%0b want 1 2 0",
                         pipe_en, state, cmd_ready);
            end
            exp_cc++;
            tick();
            checks++;
            if (pipe_en !== 1'b0 || state !== 2'b00) begin
                failures++;
                $display("FAIL step_off got pe=%0b st=%0d want 0 0", pipe_en, state);
            end
        end
        checks++;
        if (cycle_count !== 32'd3) begin
            failures++;
            $display("FAIL step_count got %0d want 3", cycle_count);
        end
    endtask

    task automatic test_run_halt_wb();
        int len;
        int highs;
        for (int r = 0; r < 2; r++) begin
            len = (r == 0) ? 10 : int'($urandom_range(3, 15));
            highs = 0;
            cmd_valid = 1'b1;
            cmd = 2'b00;
            tick();
            cmd_valid = 1'b0;
            for (int c = 1; c < len; c++) begin
                if (pipe_en === 1'b1) highs++;
                tick();
            end
            if (pipe_en === 1'b1) highs++;
            halt_wb = 1'b1;
            tick();
            halt_wb = 1'b0;
            exp_cc += len;
            checks++;
            if (highs != len) begin
                failures++;
                $display("FAIL run_highs got %0d want %0d", highs, len);
            end
            checks++;
            if (pipe_en !== 1'b0 || state !== 2'b00 || cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL run_halt got pe=%0b st=%0d rdy=%0b want 0 0 1",
                         pipe_en, state, cmd_ready);
            end
            checks++;
            if (cycle_count !== 32'(exp_cc)) begin
                failures++;
                $display("FAIL run_count got %0d want %0d", cycle_count, exp_cc);
            end
        end
    endtask

    task automatic test_run_halt_both();
        int k;
        k = int'($urandom_range(2, 8));
        cmd_valid = 1'b1;
        cmd = 2'b00;
        tick();
        cmd_valid = 1'b0;
        repeat (k) tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL both_ready got %0b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd = 2'b10;
        halt_wb = 1'b1;
        tick();
        cmd_valid = 1'b0;
        halt_wb = 1'b0;
        exp_cc += k + 1;
        checks++;
        if (pipe_en !== 1'b0 || state !== 2'b00 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL both_halt got pe=%0b st=%0d rdy=%0b want 0 0 1",
                     pipe_en, state, cmd_ready);
        end
        repeat (3) tick();
        checks++;
        if (cycle_count !== 32'(exp_cc) || state !== 2'b00) begin
            failures++;
            $display("FAIL both_after got cc=%0d st=%0d want %0d 0", cycle_count, state, exp_cc);
        end
    endtask

    // Model: idle / running / single-step, advanced once per clock edge.
    task automatic test_random_cmds();
        int  mode;
        bit  acc;
        logic [1:0] want_st;
        mode = 0;
        for (int i = 0; i < 300; i++) begin
            if (i >= 296) begin
                cmd_valid = 1'b1;
                cmd = 2'b10;
                halt_wb = 1'b0;
            end else begin
                cmd_valid = ($urandom_range(0, 3) == 0);
                cmd = 2'($urandom_range(0, 2));
                halt_wb = ($urandom_range(0, 15) == 0);
            end
            checks++;
            if (cmd_ready !== (mode != 2)) begin
                failures++;
                $display("FAIL rnd_ready i=%0d got %0b want %0b", i, cmd_ready, mode != 2);
            end
            acc = cmd_valid && (mode != 2);
            if (mode != 0) exp_cc++;
            if (mode == 2) mode = 0;
            else if (mode == 1) begin
                if (halt_wb || (acc && cmd == 2'b10)) mode = 0;
            end else if (acc) begin
                mode = (cmd == 2'b00) ? 1 : (cmd == 2'b01) ? 2 : 0;
            end
            tick();
            want_st = 2'(mode);
            checks++;
            if (pipe_en !== (mode != 0) || state !== want_st || cycle_count !== 32'(exp_cc)) begin
                failures++;
                $display("FAIL rnd_step i=%0d got pe=%0b st=%0d cc=%0d want %0b %0d %0d",
                         i, pipe_en, state, cycle_count, mode != 0, want_st, exp_cc);
            end
        end
        cmd_valid = 1'b0;
        halt_wb = 1'b0;
    endtask

    // Streams one dump; stall paces dump_ready 1-in-3; abort_at >= 0 resets there.
    task automatic run_dump(input bit stall, input int abort_at);
        int n;
        int cyc;
        bit done;
        bit was_stalled;
        logic [31:0] held;
        n = 0;
        done = 1'b0;
        was_stalled = 1'b0;
        held = '0;
        pc_v = 10'($urandom);
        for (int i = 0; i < NR; i++) regs_v[32*i +: 32] = $urandom;
        for (int j = 0; j < NM; j++) mem_v[32*j +: 32] = $urandom;
        dump_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd = 2'b11;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (dump_valid !== 1'b1 || state !== 2'b11 || pipe_en !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL dump_start got dv=%0b st=%0d pe=%0b rdy=%0b want 1 3 0 0",
                     dump_valid, state, pipe_en, cmd_ready);
        end
        for (cyc = 0; cyc < 400 && !done; cyc++) begin
            dump_ready = stall ? (cyc % 3 == 2) : 1'b1;
            if (abort_at == n) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                exp_cc = 0;
                done = 1'b1;
                checks++;
                if (dump_valid !== 1'b0 || state !== 2'b00 || cycle_count !== 32'd0 ||
                    dump_data !== 32'd0) begin
                    failures++;
                    $display("FAIL dump_abort got dv=%0b st=%0d cc=%0d dd=%h want 0 0 0 0",
                             dump_valid, state, cycle_count, dump_data);
                end
            end else begin
                if (was_stalled) begin
                    checks++;
                    if (dump_data !== held) begin
                        failures++;
                        $display("FAIL dump_hold word=%0d got %h want %h", n, dump_data, held);
                    end
                end
                checks++;
                if (dump_valid !== 1'b1 || dump_last !== (n == NW - 1)) begin
                    failures++;
                    $display("FAIL dump_flags word=%0d got dv=%0b dl=%0b want 1 %0b",
                             n, dump_valid, dump_last, n == NW - 1);
                end
                if (dump_ready) begin
                    checks++;
                    if (dump_data !== exp_word(n)) begin
                        failures++;
                        $display("FAIL dump_word word=%0d got %h want %h",
                                 n, dump_data, exp_word(n));
                    end
                    n++;
                    was_stalled = 1'b0;
                end else begin
                    held = dump_data;
                    was_stalled = 1'b1;
                end
                tick();
                if (n == NW) begin
                    done = 1'b1;
                    checks++;
                    if (dump_valid !== 1'b0 || state !== 2'b00 || cmd_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL dump_end got dv=%0b st=%0d rdy=%0b want 0 0 1",
                                 dump_valid, state, cmd_ready);
                    end
                end
            end
        end
        if (!done) begin
            failures++;
            $display("FAIL dump_timeout got %0d words want %0d", n, NW);
        end
        if (abort_at < 0) begin
            checks++;
            if (cyc != (stall ? 3 * NW : NW)) begin
                failures++;
                $display("FAIL dump_cycles got %0d want %0d", cyc, stall ? 3 * NW : NW);
            end
        end
        dump_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd = 2'b00;
        halt_wb = 1'b0;
        dump_ready = 1'b0;
        pc_v = '0;
        regs_v = '0;
        mem_v = '0;
        test_reset();
        test_step();
        test_run_halt_wb();
        test_run_halt_both();
        test_random_cmds();
        run_dump(1'b0, -1);
        run_dump(1'b1, -1);
        test_run_halt_both();
        run_dump(1'b0, 20);
        run_dump(1'b0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
